// File: rtl/risc_toy_pkg.sv
// Shared RISC_TOY definitions: address widths, reset vector default,
// the NOP encoding and the FD pipeline-register record.
package risc_toy_pkg;

  localparam int PC_W    = 32;
  localparam int IADDR_W = 30;

  localparam logic [PC_W-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0]     NOP_INSTR    = 32'h0000_0000;

  // Instruction bundle carried between pipeline stages.
  typedef struct packed {
    logic [31:0]     instr;
    logic [PC_W-1:0] pcadd4;
    logic            valid;
  } fd_bundle_t;

endpackage

// File: rtl/risc_toy_fetch_if.sv
// Instruction-memory bus: word address and request out of fetch,
// instruction data back one cycle later.
interface risc_toy_fetch_if;
  import risc_toy_pkg::*;

  logic [IADDR_W-1:0] IADDR;
  logic               IREQ;
  logic [31:0]        INSTR;

  modport master (output IADDR, output IREQ, input INSTR);
  modport slave  (input IADDR, input IREQ, output INSTR);

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding a fetched instruction and its PC+4
// while the FD register is stalled.
module fetch_skid_buf
  import risc_toy_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            load,
  input  logic            drain,
  input  logic [31:0]     instr,
  input  logic [PC_W-1:0] pcadd4,
  output fd_bundle_t      q
);

  // Occupancy flag: reset/clear empties, load fills, drain empties.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      q.valid <= 1'b0;
    end else if (load) begin
      q.valid <= 1'b1;
    end else if (drain) begin
      q.valid <= 1'b0;
    end
  end

  // Payload is only meaningful while valid, so it is captured without reset.
  always_ff @(posedge clk) begin
    if (load) begin
      q.instr  <= instr;
      q.pcadd4 <= pcadd4;
    end
  end

endmodule

// File: rtl/risc_toy_fetch.sv
// RISC_TOY instruction-fetch stage with FD pipeline register.
// Issues one word fetch per cycle to a 1-cycle-latency memory, absorbs the
// in-flight response into a skid buffer on stall, and flushes on redirect.
// Optional build macro FETCH_PERF_EN adds fetch/flush performance counters.
module risc_toy_fetch
  import risc_toy_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                STALL,
  input  logic                REDIR,
  input  logic [PC_W-1:0]     REDIR_TGT,
  risc_toy_fetch_if.master    imem,
  output logic [31:0]         INSTR_D,
  output logic [PC_W-1:0]     PCADD4_D,
  output logic                VALID_D,
  output logic [31:0]         FETCH_CNT,
  output logic [31:0]         FLUSH_CNT
);

  logic [PC_W-1:0] pc_q;
  logic            infl_q;
  logic [PC_W-1:0] infl_pc_q;
  logic [PC_W-1:0] infl_pc4;
  logic            issue;
  logic [PC_W-1:0] issue_addr;
  logic            skid_load;
  logic            skid_drain;
  logic            fd_load_valid;
  logic            unused_tgt_lsb;
  fd_bundle_t      skid_q;
  fd_bundle_t      fd_q;

  assign unused_tgt_lsb = ^REDIR_TGT[1:0];
  assign infl_pc4       = infl_pc_q + 32'd4;

  // Issue selection: redirect beats stall, stall suppresses the request.
  always_comb begin
    issue      = REDIR || !STALL;
    issue_addr = REDIR ? {REDIR_TGT[PC_W-1:2], 2'b00} : pc_q;
  end

  assign imem.IADDR = issue_addr[PC_W-1:2];
  assign imem.IREQ  = issue && !RST;

  // PC and in-flight tracking; a fetch issued this cycle returns next cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q   <= RESET_PC;
      infl_q <= 1'b0;
    end else if (issue) begin
      pc_q      <= issue_addr + 32'd4;
      infl_q    <= 1'b1;
      infl_pc_q <= issue_addr;
    end else begin
      infl_q <= 1'b0;
    end
  end

  // The skid fills only on a stall with a response arriving, drains on the
  // first free cycle, and is discarded by a redirect.
  assign skid_load  = !REDIR && STALL && infl_q;
  assign skid_drain = !REDIR && !STALL && skid_q.valid;

  fetch_skid_buf u_skid (
    .clk    (CLK),
    .rst    (RST),
    .clear  (REDIR),
    .load   (skid_load),
    .drain  (skid_drain),
    .instr  (imem.INSTR),
    .pcadd4 (infl_pc4),
    .q      (skid_q)
  );

  // FD register: bubble on reset/redirect, hold on stall, else prefer the
  // older skid entry over the live memory response.
  always_ff @(posedge CLK) begin
    if (RST || REDIR) begin
      fd_q.valid <= 1'b0;
      fd_q.instr <= NOP_INSTR;
      if (RST) begin
        fd_q.pcadd4 <= '0;
      end
    end else if (!STALL) begin
      if (skid_q.valid) begin
        fd_q <= skid_q;
      end else if (infl_q) begin
        fd_q.instr  <= imem.INSTR;
        fd_q.pcadd4 <= infl_pc4;
        fd_q.valid  <= 1'b1;
      end else begin
        fd_q.valid <= 1'b0;
        fd_q.instr <= NOP_INSTR;
      end
    end
  end

  assign INSTR_D  = fd_q.instr;
  assign PCADD4_D = fd_q.pcadd4;
  assign VALID_D  = fd_q.valid;

  assign fd_load_valid = !RST && !REDIR && !STALL && (skid_q.valid || infl_q);

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] flush_cnt_q;

  // Performance counters: valid FD loads and redirect cycles, wrapping.
  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (fd_load_valid) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (REDIR) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign FETCH_CNT = fetch_cnt_q;
  assign FLUSH_CNT = flush_cnt_q;
`else
  logic unused_fd_load_valid;
  assign unused_fd_load_valid = fd_load_valid;
  assign FETCH_CNT = '0;
  assign FLUSH_CNT = '0;
`endif

endmodule
